// File: rtl/seq_divider4_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and default width.
package seq_divider4_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider4_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract D,
// keep the difference when it does not borrow.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] r,
  input  logic         q_msb,
  input  logic [N-1:0] d,
  output logic [N-1:0] r_next,
  output logic         q_bit
);

  logic [N:0] r_shift;
  logic [N:0] trial;

  always_comb begin
    r_shift = {r, q_msb};
    trial   = r_shift - {1'b0, d};
    q_bit   = ~trial[N];
    // Either branch is below D, so the restored remainder always fits in N bits.
    r_next  = q_bit ? trial[N-1:0] : r_shift[N-1:0];
  end

endmodule

// File: rtl/seq_divider4.sv
// Sequential unsigned restoring divider: one quotient bit per clock, N iterations,
// registered quotient/remainder with a one-cycle done strobe.
module seq_divider4
  import seq_divider4_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N-1:0]  step_r;
  logic          step_q_bit;
  logic [N-1:0]  q_shift;

  div_step #(.N(N)) u_step (
    .r      (r_q),
    .q_msb  (q_q[N-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_q_bit)
  );

  always_comb begin
    q_shift = (q_q << 1) | N'(step_q_bit);

    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          d_d     = divisor;
          q_d     = dividend;
          r_d     = '0;
          count_d = CW'(N - 1);
          if (divisor == '0) begin
            // Nothing to iterate: publish the saturated result immediately.
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        r_d = step_r;
        q_d = q_shift;
        if (count_q == '0) begin
          state_d = ST_DONE;
          quot_d  = q_shift;
          rem_d   = step_r;
          dbz_d   = 1'b0;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider4.sv
// Directed plus randomized bench for seq_divider4, checked against plain integer division.
module tb_seq_divider4;

  localparam int N = 4;
  localparam int MAXV = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider4 #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge; returns edges-to-done and busy cycles seen.
  task automatic wait_done(output int lat, output int bcnt);
    bit ok;
    lat = 0;
    bcnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    chk("done_timeout", 32'(ok), 32'd1);
  endtask

  task automatic check_result(input int a, input int b, input int lat, input int bcnt);
    int eq, er, edbz, elat, ebusy;
    if (b == 0) begin
      eq = MAXV; er = a; edbz = 1; elat = 0; ebusy = 1;
    end else begin
      eq = a / b; er = a % b; edbz = 0; elat = N; ebusy = N + 1;
    end
    $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d latency=%0d busy=%0d",
             a, b, quotient, remainder, div_by_zero, lat, bcnt);
    chk("latency", 32'(lat), 32'(elat));
    chk("busy_cycles", 32'(bcnt), 32'(ebusy));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(edbz));
    if (b != 0) begin
      chk("identity", 32'(int'(quotient) * b + int'(remainder)), 32'(a));
      chk("rem_lt_div", 32'(int'(remainder) < b), 32'd1);
    end
  endtask

  task automatic run_op(input int a, input int b);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1;
    dividend = N'(a);
    divisor = N'(b);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt);
    check_result(a, b, lat, bcnt);
    @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("hold_quotient", 32'(quotient), 32'(b == 0 ? MAXV : a / b));
  endtask

  initial begin
    int lat, bcnt;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    // Directed operations
    run_op(13, 4);
    run_op(15, 1);
    run_op(3, 9);
    run_op(0, 5);
    run_op(7, 0);
    run_op(15, 15);

    // start held high; operands changed mid-CALC must not disturb the first result
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd9;
    divisor = 4'd2;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd2;
    divisor = 4'd2;
    @(posedge clk);
    wait_done(lat, bcnt);
    lat = lat + 1;
    bcnt = bcnt + 1;
    check_result(9, 2, lat, bcnt);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt);
    check_result(2, 2, lat, bcnt);
    @(posedge clk);

    // Reset during CALC aborts the operation
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd14;
    divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    run_op(14, 3);

    // Exhaustive sweep of all operand pairs
    for (int a = 0; a <= MAXV; a++)
      for (int b = 0; b <= MAXV; b++)
        run_op(a, b);

    // Randomized operations
    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(MAXV, 0)), int'($urandom_range(MAXV, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
